// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use bubbles, branch
// flushes, memory freezes with deferred flush, and saturating event counters.
module pipe_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_ex_mem_read_i,
    input  logic [REG_W-1:0] id_ex_rd_i,
    input  logic [REG_W-1:0] if_id_rs1_i,
    input  logic [REG_W-1:0] if_id_rs2_i,
    input  logic             branch_taken_i,
    input  logic             mem_stall_i,
    output logic             pc_write_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             pipe_mem_stall_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic       pend;
    logic       pend_nxt;
    logic       hz;
    logic       flush_req;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        hz = id_ex_mem_read_i && (id_ex_rd_i != '0) &&
             ((id_ex_rd_i == if_id_rs1_i) || (id_ex_rd_i == if_id_rs2_i));
    end

    // A branch seen while frozen is remembered in pend and replayed on release,
    // because the IF/ID register cannot honour a flush while it is held.
    always_comb begin
        flush_req = (branch_taken_i || ((state == MEM_WAIT) && pend)) && !hz;
    end

    always_comb begin
        pc_write_o       = 1'b0;
        if_id_stall_o    = 1'b0;
        if_id_flush_o    = 1'b0;
        id_ex_bubble_o   = 1'b0;
        pipe_mem_stall_o = 1'b0;
        if (rst_i) begin
            if (mem_stall_i) begin
                pipe_mem_stall_o = 1'b1;
                if_id_stall_o    = 1'b1;
            end else if (hz) begin
                if_id_stall_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
            end else if (flush_req) begin
                pc_write_o    = 1'b1;
                if_id_flush_o = 1'b1;
            end else begin
                pc_write_o = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        if (state == RUN) begin
            if (mem_stall_i) begin
                state_nxt = MEM_WAIT;
                pend_nxt  = branch_taken_i && !hz;
            end else begin
                pend_nxt = 1'b0;
            end
        end else begin
            if (mem_stall_i) begin
                pend_nxt = pend || (branch_taken_i && !hz);
            end else begin
                state_nxt = RUN;
                pend_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= RUN;
            pend        <= 1'b0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            if (if_id_stall_o) begin
                stall_cnt_o <= sat_inc(stall_cnt_o);
            end
            if (if_id_flush_o) begin
                flush_cnt_o <= sat_inc(flush_cnt_o);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a 32-bit and a 2-bit counter instance
// share stimulus and are checked against a per-cycle behavioural model.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       br;
    logic       ms;

    logic        pcw, stl, fls, bub, pms;
    logic [31:0] scnt, fcnt;
    logic        pcw2, stl2, fls2, bub2, pms2;
    logic [1:0]  scnt2, fcnt2;

    int checks = 0;
    int errors = 0;

    // Model state: owed flush while frozen, event counts, and a start gate.
    bit      owed;
    longint  m_sc, m_fc;
    int      m_sc2, m_fc2;
    bit      model_ok = 0;

    pipe_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .id_ex_mem_read_i(mr), .id_ex_rd_i(rd),
        .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .branch_taken_i(br), .mem_stall_i(ms),
        .pc_write_o(pcw), .if_id_stall_o(stl), .if_id_flush_o(fls),
        .id_ex_bubble_o(bub), .pipe_mem_stall_o(pms),
        .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
    );

    pipe_hazard_ctrl #(.REG_W(5), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .id_ex_mem_read_i(mr), .id_ex_rd_i(rd),
        .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .branch_taken_i(br), .mem_stall_i(ms),
        .pc_write_o(pcw2), .if_id_stall_o(stl2), .if_id_flush_o(fls2),
        .id_ex_bubble_o(bub2), .pipe_mem_stall_o(pms2),
        .stall_cnt_o(scnt2), .flush_cnt_o(fcnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected controls as {pc_write, stall, flush, bubble, mem_stall}.
    function automatic logic [4:0] model_ctrl();
        bit hazard;
        hazard = mr && rd != 0 && (rd == rs1 || rd == rs2);
        if (!rst)                 return 5'b00000;
        if (ms)                   return 5'b01001;
        if (hazard)               return 5'b01010;
        if (br || owed)           return 5'b10100;
        return 5'b10000;
    endfunction

    always @(posedge clk) begin
        logic [4:0] e;
        bit hazard;
        hazard = mr && rd != 0 && (rd == rs1 || rd == rs2);
        if (!rst) begin
            owed = 0; m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
            model_ok = 1;
        end else if (model_ok) begin
            e = model_ctrl();
            if (e[3]) begin
                if (m_sc < 64'hFFFF_FFFF) m_sc++;
                if (m_sc2 < 3) m_sc2++;
            end
            if (e[2]) begin
                if (m_fc < 64'hFFFF_FFFF) m_fc++;
                if (m_fc2 < 3) m_fc2++;
            end
            owed = ms ? (owed || (br && !hazard)) : 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [4:0] e;
        if (model_ok) begin
            e = model_ctrl();
            chk("cmp_ctrl",     {59'd0, pcw, stl, fls, bub, pms},      {59'd0, e});
            chk("cmp_ctrl_sat", {59'd0, pcw2, stl2, fls2, bub2, pms2}, {59'd0, e});
            chk("cmp_stall_cnt", {32'd0, scnt}, m_sc[63:0]);
            chk("cmp_flush_cnt", {32'd0, fcnt}, m_fc[63:0]);
            chk("cmp_stall_cnt_sat", {62'd0, scnt2}, 64'(m_sc2));
            chk("cmp_flush_cnt_sat", {62'd0, fcnt2}, 64'(m_fc2));
        end
    end

    task automatic drive(input logic r, input logic m, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic b, input logic st);
        @(posedge clk);
        #1;
        rst = r; mr = m; rd = d; rs1 = s1; rs2 = s2; br = b; ms = st;
        @(negedge clk);
    endtask

    // Literal check of {pc_write, stall, flush, bubble, mem_stall}.
    task automatic lit(input string name, input logic [4:0] exp);
        chk(name, {59'd0, pcw, stl, fls, bub, pms}, {59'd0, exp});
    endtask

    initial begin
        rst = 0; mr = 0; rd = 0; rs1 = 0; rs2 = 0; br = 0; ms = 0;
        // Reset with inputs that would otherwise stall and hazard.
        drive(0, 1, 5'd5, 5'd5, 5'd0, 1, 1);
        drive(0, 1, 5'd5, 5'd5, 5'd0, 1, 1);
        lit("reset_outputs", 5'b00000);
        chk("reset_stall_cnt", {32'd0, scnt}, 64'd0);
        chk("reset_flush_cnt", {32'd0, fcnt}, 64'd0);

        drive(1, 0, 0, 0, 0, 0, 0);
        lit("idle", 5'b10000);

        // Load-use hazard
        drive(1, 1, 5'd5, 5'd5, 5'd0, 0, 0);
        lit("load_use", 5'b01010);
        chk("load_use_cnt_before", {32'd0, scnt}, 64'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("load_use_cnt_after", {32'd0, scnt}, 64'd1);

        // rd=0 never hazards
        drive(1, 1, 5'd0, 5'd0, 5'd0, 0, 0);
        lit("rd_zero", 5'b10000);

        // Branch flush
        drive(1, 0, 0, 0, 0, 1, 0);
        lit("branch", 5'b10100);
        drive(1, 0, 0, 0, 0, 0, 0);
        lit("branch_one_cycle", 5'b10000);
        chk("branch_flush_cnt", {32'd0, fcnt}, 64'd1);

        // Deferred flush across a 3-cycle memory stall
        drive(1, 0, 0, 0, 0, 1, 1);
        lit("defer_stall1", 5'b01001);
        drive(1, 0, 0, 0, 0, 0, 1);
        lit("defer_stall2", 5'b01001);
        drive(1, 0, 0, 0, 0, 0, 1);
        lit("defer_stall3", 5'b01001);
        drive(1, 0, 0, 0, 0, 0, 0);
        lit("defer_release", 5'b10100);
        drive(1, 0, 0, 0, 0, 0, 0);
        lit("defer_after", 5'b10000);
        chk("defer_flush_cnt", {32'd0, fcnt}, 64'd2);
        chk("defer_stall_cnt", {32'd0, scnt}, 64'd4);

        // Reset while a flush is pending discards it
        drive(1, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        lit("mid_reset", 5'b00000);
        drive(1, 0, 0, 0, 0, 0, 0);
        lit("mid_reset_no_flush", 5'b10000);
        chk("mid_reset_stall_cnt", {32'd0, scnt}, 64'd0);
        chk("mid_reset_flush_cnt", {32'd0, fcnt}, 64'd0);

        // Memory stall beats hazard; hazard re-evaluated on release
        drive(1, 1, 5'd3, 5'd0, 5'd3, 0, 1);
        lit("stall_over_hz", 5'b01001);
        drive(1, 1, 5'd3, 5'd0, 5'd3, 0, 0);
        lit("hz_after_release", 5'b01010);

        // Pending flush blocked by hazard on release, then dropped
        drive(1, 0, 0, 0, 0, 1, 1);
        drive(1, 1, 5'd7, 5'd7, 5'd0, 0, 0);
        lit("pend_blocked_by_hz", 5'b01010);
        drive(1, 0, 0, 0, 0, 0, 0);
        lit("pend_dropped", 5'b10000);

        // Saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) drive(1, 1, 5'd9, 5'd1, 5'd9, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("sat_stall_cnt2", {62'd0, scnt2}, 64'd3);
        chk("sat_stall_cnt32", {32'd0, scnt}, 64'd9);
        chk("sat_flush_cnt2", {62'd0, fcnt2}, 64'd0);

        // Mixed vectors over a small register space, checked by the model
        for (int i = 0; i < 60; i++) begin
            drive(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0));
        end

        drive(1, 0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the five-stage pipeline.
- Drives the IF/ID register's stall and flush inputs, the PC write enable, the ID/EX bubble and the global memory-stall line.
- Resolves load-use hazards, taken-branch flushes and data-memory stalls.
- Defers any flush that collides with a memory stall until the stall releases, because the IF/ID register ignores flush while stalled.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 32, width of each performance counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-low.
- id_ex_mem_read_i  in  1  instruction in EX is a load.
- id_ex_rd_i  in  REG_W  destination register of the instruction in EX.
- if_id_rs1_i  in  REG_W  rs1 of the instruction in ID.
- if_id_rs2_i  in  REG_W  rs2 of the instruction in ID.
- branch_taken_i  in  1  branch resolved taken in ID this cycle.
- mem_stall_i  in  1  data memory busy; pipeline must freeze.
- pc_write_o  out  1  PC register update enable.
- if_id_stall_o  out  1  hold the IF/ID register.
- if_id_flush_o  out  1  zero the IF/ID register.
- id_ex_bubble_o  out  1  insert a NOP into ID/EX.
- pipe_mem_stall_o  out  1  freeze all pipe registers.
- stall_cnt_o  out  CNT_W  cycles with if_id_stall_o=1.
- flush_cnt_o  out  CNT_W  cycles with if_id_flush_o=1.

Behaviour:
- Hazard term: hz = id_ex_mem_read_i && id_ex_rd_i!=0 && (id_ex_rd_i==if_id_rs1_i || id_ex_rd_i==if_id_rs2_i).
- Reset: at a posedge with rst_i=0, state<=RUN, pend<=0, both counters<=0.
- While rst_i=0, all control outputs are forced to 0.
- Control outputs are combinational from state, pend and the inputs. State, pend and the counters are registered.
- State RUN, mem_stall_i=1:
  - pipe_mem_stall_o=1, if_id_stall_o=1, pc_write_o=0, if_id_flush_o=0, id_ex_bubble_o=0.
  - pend<=branch_taken_i && !hz; next state MEM_WAIT.
- State RUN, mem_stall_i=0, hz=1:
  - pc_write_o=0, if_id_stall_o=1, id_ex_bubble_o=1, if_id_flush_o=0.
  - branch_taken_i is ignored, since the branch operand is not yet valid.
  - Stays RUN.
- State RUN, mem_stall_i=0, hz=0, branch_taken_i=1:
  - pc_write_o=1, if_id_flush_o=1, if_id_stall_o=0, id_ex_bubble_o=0. Stays RUN.
- State RUN, otherwise: pc_write_o=1, all other control outputs 0.
- State MEM_WAIT, mem_stall_i=1:
  - Same outputs as RUN with mem_stall_i=1.
  - pend<=pend | (branch_taken_i && !hz).
- State MEM_WAIT, mem_stall_i=0 (release cycle):
  - Outputs are evaluated exactly as in RUN.
  - The flush condition becomes (pend | branch_taken_i) && !hz.
  - Next state RUN, pend<=0.
- if_id_flush_o and if_id_stall_o are never both 1 in the same cycle.
- Simultaneous mem_stall_i and hz: the memory stall wins. No bubble is inserted; hz is re-evaluated after release.
- Counters:
  - Each increments by 1 on cycles where its output is 1 and rst_i=1.
  - Each saturates at 2^CNT_W-1 with no wrap.
- Reset mid-MEM_WAIT: pend is discarded, state returns to RUN, counters are cleared.

Test Plan:
- Load-use: mem_read=1, rd=5, rs1=5, no mem stall -> that cycle pc_write=0, if_id_stall=1, id_ex_bubble=1; stall_cnt goes 0->1.
- rd=0 with mem_read=1 and rs1=0 -> no hazard; pc_write=1, stall=0, bubble=0.
- Branch without hazard: branch_taken=1 -> if_id_flush=1, pc_write=1 for exactly one cycle; flush_cnt=1.
- Deferred flush: mem_stall=1 for 3 cycles with branch_taken=1 in the first cycle only -> 3 cycles of stall=1/flush=0, then flush=1 in the release cycle; flush_cnt=1, stall_cnt=3.
- Reset during MEM_WAIT with pend=1: rst_i=0 for one edge, then mem_stall=0 -> no flush issued; counters read 0.
- Saturation with CNT_W=2: 5 consecutive load-use stall cycles -> stall_cnt sticks at 3.
